bist_lockstep_engine: RTL
=========================

Name: bist_lockstep_engine

Overview:
Synthesizable stimulus-and-compare engine that acts as the driving and checking end of a golden-versus-netlist lockstep pair. It generates pseudo-random input vectors from an LFSR and sequences the DUT reset. Both DUT copies' responses are sampled after a fixed hold time, mismatches are counted, and the golden response stream is compacted into a MISR signature. It sits in the top-level harness wrapper, with the two DUT instances hanging off its stim and resp ports.

Parameters:
IN_W, 8, stimulus width driven to both DUTs (1..32)
DATA_W, 32, response width from each DUT
NUM_VECTORS, 1000, random vectors applied per run (1..65535)
HOLD_CYCLES, 2, cycles each vector (and the reset phase) is held before compare (>=1)
LFSR_SEED, 32'h0000_0001, LFSR load value at run start (must be non-zero)

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
abort  in  1  one-cycle pulse; returns to IDLE from any state
dut_rst  out  1  active-high reset to both DUT copies
stim  out  IN_W  stimulus to both DUT copies
resp_golden  in  DATA_W  golden DUT output
resp_netlist  in  DATA_W  netlist DUT output
busy  out  1  high in RESET and RUN
done  out  1  high in DONE
pass  out  1  valid in DONE: mismatch_cnt==0
mismatch_cnt  out  16  saturating mismatch count
vec_cnt  out  16  vectors completed this run
signature  out  DATA_W  MISR over golden responses

Behaviour:
- Reset (rst=0, async): state=IDLE; stim=0, dut_rst=0, busy=0, done=0, pass=0, mismatch_cnt=0, vec_cnt=0, signature=0; lfsr=LFSR_SEED; hold counter=0. A reset mid-run discards the run with no partial result.
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE -> RESET on start. DONE -> RESET on start (re-run). In RESET, the following are cleared: mismatch_cnt, vec_cnt, signature, and lfsr (reloaded to LFSR_SEED).
- RESET:
  - dut_rst=1, stim=0 for HOLD_CYCLES cycles.
  - On the last cycle, the responses are compared (counts toward mismatch_cnt, not vec_cnt) and MISR-folded.
  - Transition to RUN, dut_rst=0.
- RUN: each vector is a HOLD_CYCLES-cycle slot.
  - stim=lfsr[IN_W-1:0] is registered at slot start and held stable for the whole slot.
  - On the last slot cycle, resp_golden is compared with resp_netlist (!=). On a difference, mismatch_cnt increments, saturating at 16'hFFFF.
  - On the same cycle: signature updates; vec_cnt increments; lfsr advances.
  - After vec_cnt reaches NUM_VECTORS -> DONE.
- DONE: done=1, busy=0, pass=(mismatch_cnt==0); stim holds its last value; counters and signature are frozen.
- start while busy is ignored. abort has priority over start. abort in any state -> IDLE; dut_rst=0; counters retain their values; done=0.
- LFSR advance: next={lfsr[30:0],1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 0). Vector 0 uses LFSR_SEED.
- MISR: sig_next={sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? 32'h0040_0007[DATA_W-1:0] : 0) ^ resp_golden.
- All outputs are registered; no combinational path from resp_* to any output.

Optional Feature:
BIST_FIRST_FAIL_CAPTURE_EN:
- Defined: adds outputs fail_valid(1), fail_index(16), fail_golden(DATA_W), fail_netlist(DATA_W).
  - The first mismatch of a run latches vec_cnt (16'hFFFF if it occurs in the RESET phase) and both responses, and sets fail_valid.
  - Later mismatches do not overwrite the capture.
  - All four outputs are cleared by rst and on entry to RESET.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, resp_golden tied to resp_netlist from a passthrough model, start pulse:
  - busy high for 2+2000 cycles;
  - stim sequence for vectors 0..8 is 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x00;
  - done=1, pass=1, vec_cnt=1000, mismatch_cnt=0.
- Netlist model inverts bit 0 only when stim==0x04 -> exactly 1 mismatch, pass=0. With BIST_FIRST_FAIL_CAPTURE_EN: fail_index=2 and fail_valid=1.
- resp_netlist differs on every compare, NUM_VECTORS=65535 -> mismatch_cnt saturates at 16'hFFFF with no wrap.
- abort pulsed at vector 10 -> IDLE next cycle, dut_rst=0, busy=0; a subsequent start reruns and reproduces an identical signature.
- rst driven low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; start after release gives a full, correct run.
- start pulsed during RUN and during DONE -> ignored in RUN; in DONE a rerun occurs with counters cleared and the same signature as the first run.

Source files
------------

// File: rtl/bist_lockstep_engine.sv
// bist_lockstep_engine: LFSR stimulus generator, lockstep response comparator and MISR compactor.
// Ports: clk; rst (async, active-low); start/abort one-cycle pulses;
//   dut_rst/stim drive both DUT copies; resp_golden/resp_netlist sampled on the last cycle of each hold slot;
//   busy (RESET/RUN), done, pass; mismatch_cnt (saturating), vec_cnt, signature (MISR over golden).
// Optional macro BIST_FIRST_FAIL_CAPTURE_EN adds fail_valid, fail_index, fail_golden, fail_netlist.
module bist_lockstep_engine #(
  parameter int IN_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_VECTORS = 1000,
  parameter int HOLD_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic dut_rst,
  output logic [IN_W-1:0] stim,
  input  logic [DATA_W-1:0] resp_golden,
  input  logic [DATA_W-1:0] resp_netlist,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] vec_cnt,
  output logic [DATA_W-1:0] signature
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
  ,
  output logic fail_valid,
  output logic [15:0] fail_index,
  output logic [DATA_W-1:0] fail_golden,
  output logic [DATA_W-1:0] fail_netlist
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RESET = 2'd1, RUN = 2'd2, DONE = 2'd3;
  localparam logic [DATA_W-1:0] MISR_POLY = DATA_W'(32'h0040_0007);
  logic [1:0] state;
  logic [31:0] lfsr, lfsr_next;
  logic [15:0] hold, mm_next;
  logic [DATA_W-1:0] sig_next;
  logic slot_end, differ, last_vec, launch;
  assign lfsr_next = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 32'h0);
  assign sig_next = {signature[DATA_W-2:0], 1'b0} ^ (signature[DATA_W-1] ? MISR_POLY : '0) ^ resp_golden;
  assign slot_end = hold == 16'(HOLD_CYCLES - 1);
  assign differ = resp_golden != resp_netlist;
  assign mm_next = mismatch_cnt + {15'd0, differ && mismatch_cnt != 16'hFFFF};
  assign last_vec = vec_cnt == 16'(NUM_VECTORS - 1);
  // busy is high exactly in RESET/RUN, so !busy means IDLE or DONE where start is honoured
  assign launch = start && !abort && !busy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      stim <= '0;
      dut_rst <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      mismatch_cnt <= '0;
      vec_cnt <= '0;
      signature <= '0;
      lfsr <= LFSR_SEED;
      hold <= '0;
    end else if (abort) begin
      state <= IDLE;
      dut_rst <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (launch) begin
      state <= RESET;
      stim <= '0;
      dut_rst <= 1'b1;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      mismatch_cnt <= '0;
      vec_cnt <= '0;
      signature <= '0;
      lfsr <= LFSR_SEED;
      hold <= '0;
    end else if (state == RESET || state == RUN) begin
      hold <= slot_end ? '0 : hold + 16'd1;
      if (slot_end) begin
        mismatch_cnt <= mm_next;
        signature <= sig_next;
        if (state == RESET) begin
          state <= RUN;
          dut_rst <= 1'b0;
          stim <= lfsr[IN_W-1:0];
        end else begin
          vec_cnt <= vec_cnt + 16'd1;
          lfsr <= lfsr_next;
          if (last_vec) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= mm_next == 16'd0;
          end else begin
            stim <= lfsr_next[IN_W-1:0];
          end
        end
      end
    end
  end
`ifdef BIST_FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || launch) begin
      fail_valid <= 1'b0;
      fail_index <= '0;
      fail_golden <= '0;
      fail_netlist <= '0;
    end else if (!abort && busy && slot_end && differ && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_index <= state == RESET ? 16'hFFFF : vec_cnt;
      fail_golden <= resp_golden;
      fail_netlist <= resp_netlist;
    end
  end
`endif
endmodule
